ahb_split_ctrl: RTL and testbench
=================================

Name: ahb_split_ctrl

Overview:
- Slave-side SPLIT controller. Sits between a shared, non-reentrant slave resource and the AHB arbiter.
- While the resource is busy, it answers new non-locked transfers with a two-cycle SPLIT response and records the requesting master. It then releases recorded masters on HSPLITx, one per cycle, once the resource is free.
- Locked transfers are never split; they are held with wait states instead.

Parameters:
- NUM_MASTERS, 16: masters tracked; width of HSPLITx. Legal range 1..16.
- MID_W, 4: width of HMASTER.

Ports:
- HCLK  in  1  bus clock; all logic on posedge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HREADY  in  1  bus-wide ready.
- HMASTER  in  MID_W  current address-phase master.
- HMASTLOCK  in  1  locked-sequence indicator.
- res_busy  in  1  shared resource is occupied.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  response (00 OKAY, 11 SPLIT).
- HSPLITx  out  NUM_MASTERS  one-hot release pulse to arbiter.
- xfer_accept  out  1  1-cycle pulse: transfer accepted, resource may start.
- split_pending  out  NUM_MASTERS  recorded split masters (debug/status).

Behaviour:
- Reset: HREADYOUT=1, HRESP=OKAY, HSPLITx=0, xfer_accept=0, split_pending=0, state=IDLE, release pointer=0. Reset mid-SPLIT or mid-WAIT_LOCK aborts to IDLE and clears pending.
- Address-phase valid (av) = HSEL & HTRANS[1] & HREADY. IDLE/BUSY transfers get a zero-wait OKAY.
- State IDLE (HREADYOUT=1, HRESP=OKAY):
  - av & !res_busy -> xfer_accept=1 in that same cycle; stay in IDLE.
  - av & res_busy & !HMASTLOCK -> set pending[HMASTER]; go to SPLIT1.
  - av & res_busy & HMASTLOCK -> go to WAIT_LOCK.
- SPLIT1: HREADYOUT=0, HRESP=SPLIT; go to SPLIT2 unconditionally.
- SPLIT2: HREADYOUT=1, HRESP=SPLIT; go to IDLE. A new av in this cycle is ignored, because HREADY is high and the master must cancel.
- WAIT_LOCK: HREADYOUT=0, HRESP=OKAY.
  - Leave when res_busy=0: pulse xfer_accept, go to IDLE with HREADYOUT=1 next cycle.
  - No timeout.
- Release: when res_busy=0 and pending!=0, HSPLITx is the one-hot of the first set pending bit at or after the round-robin pointer, wrapping at NUM_MASTERS-1 -> 0.
  - The HSPLITx output is registered: it is asserted the cycle after selection.
  - The selected bit is cleared in the same edge; the pointer moves to selected+1 (mod NUM_MASTERS).
  - At most one HSPLITx bit is set per cycle.
- While res_busy=1, HSPLITx=0. Splitting and releasing are mutually exclusive on res_busy.
- A split of a master already pending leaves its bit set (idempotent). HMASTER >= NUM_MASTERS is not recorded but still receives the SPLIT response.
- Invariants:
  - At most one HSPLITx bit is set at any time.
  - HRESP=SPLIT only in SPLIT1/SPLIT2.
  - HREADYOUT=0 only in SPLIT1 or WAIT_LOCK.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp_t constants (OKAY, ERROR, RETRY, SPLIT).
  - split_state_t enum (IDLE, SPLIT1, SPLIT2, WAIT_LOCK).
  - MAX_MASTERS = 16.
- One sub-module, rr_pick, picks the round-robin first set bit from the pending mask and pointer. It is combinational, reusable, and tested in isolation.

Test Plan:
- Free resource: HSEL=1, HTRANS=NONSEQ, HMASTER=3, res_busy=0 -> xfer_accept pulse same cycle; HRESP=OKAY; HREADYOUT stays 1; HSPLITx=0.
- Busy split: res_busy=1, av from master 5 -> next two cycles HREADYOUT=0/1 with HRESP=SPLIT,SPLIT; split_pending=0x0020; HSPLITx=0 while busy.
- Release order: pending masters 2, 7, 12 with pointer=8, then res_busy drops -> HSPLITx=0x1000, 0x0004, 0x0080 on consecutive cycles; pending ends 0.
- Locked hold: res_busy=1, av with HMASTLOCK=1 from master 1 for 4 cycles -> HREADYOUT=0, HRESP=OKAY, no pending bit set; res_busy falls -> xfer_accept, then HREADYOUT=1.
- Reset mid-operation: HRESET during SPLIT1 with pending=0x0006 -> next cycle HREADYOUT=1, HRESP=OKAY, pending=0, HSPLITx=0.
- Assertions across random traffic:
  - popcount(HSPLITx) <= 1.
  - HSPLITx bits are only ever set for bits previously set in pending.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the SPLIT controller.
package ahb_pkg;

  localparam int unsigned MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef logic [1:0] hresp_t;

  localparam hresp_t RespOkay  = 2'b00;
  localparam hresp_t RespError = 2'b01;
  localparam hresp_t RespRetry = 2'b10;
  localparam hresp_t RespSplit = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSplit1,
    StSplit2,
    StWaitLock
  } split_state_t;

  // Index width for a set of n masters; never zero so a single master still has a pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at N-1 -> 0.
module rr_pick #(
  parameter int unsigned N    = 16,
  parameter int unsigned PtrW = ahb_pkg::ptr_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic            valid_o,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o
);

  localparam int unsigned SumW = PtrW + 1;

  logic [SumW-1:0] sum;
  logic [PtrW-1:0] k;

  // Scan from the pointer; the extra sum bit lets the wrap work for non-power-of-two N.
  always_comb begin
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    sum     = '0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + SumW'(i);
      if (sum >= SumW'(N)) begin
        sum = sum - SumW'(N);
      end
      k = sum[PtrW-1:0];
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/ahb_split_ctrl.sv
// Slave-side SPLIT controller guarding a shared, non-reentrant resource.
module ahb_split_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 16,
  parameter int unsigned MID_W       = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic [MID_W-1:0]       HMASTER,
  input  logic                   HMASTLOCK,
  input  logic                   res_busy,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HSPLITx,
  output logic                   xfer_accept,
  output logic [NUM_MASTERS-1:0] split_pending
);

  localparam int unsigned PtrW = ptr_width(NUM_MASTERS);

  split_state_t           state_q, state_d;
  logic [NUM_MASTERS-1:0] pending_q, pending_d;
  logic [NUM_MASTERS-1:0] hsplit_q, hsplit_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;

  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PtrW-1:0]        pick_idx;

  htrans_t                trans;
  logic                   av;
  logic                   record_split;

  assign trans = htrans_t'(HTRANS);
  assign av    = HSEL && HREADY && (trans == TransNonseq || trans == TransSeq);

  rr_pick #(
    .N    (NUM_MASTERS),
    .PtrW (PtrW)
  ) u_rr_pick (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  // Response FSM: next state plus state-decoded HREADYOUT/HRESP and the accept pulse.
  always_comb begin
    state_d      = state_q;
    HREADYOUT    = 1'b1;
    HRESP        = RespOkay;
    xfer_accept  = 1'b0;
    record_split = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (av) begin
          if (!res_busy) begin
            xfer_accept = 1'b1;
          end else if (!HMASTLOCK) begin
            record_split = 1'b1;
            state_d      = StSplit1;
          end else begin
            state_d = StWaitLock;
          end
        end
      end
      StSplit1: begin
        HREADYOUT = 1'b0;
        HRESP     = RespSplit;
        state_d   = StSplit2;
      end
      StSplit2: begin
        // The master must cancel whatever it presents here, so av is ignored.
        HRESP   = RespSplit;
        state_d = StIdle;
      end
      StWaitLock: begin
        HREADYOUT = 1'b0;
        if (!res_busy) begin
          xfer_accept = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending mask, registered release pulse and round-robin pointer.
  always_comb begin
    pending_d = pending_q;
    hsplit_d  = '0;
    ptr_d     = ptr_q;
    if (record_split) begin
      // Out-of-range master IDs match no bit and are simply not recorded.
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (32'(HMASTER) == i) begin
          pending_d[i] = 1'b1;
        end
      end
    end
    // Recording needs res_busy=1 and releasing needs res_busy=0, so they never overlap.
    if (!res_busy && pick_valid) begin
      hsplit_d  = pick_gnt;
      pending_d = pending_q & ~pick_gnt;
      ptr_d     = (pick_idx == PtrW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      pending_q <= '0;
      hsplit_q  <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hsplit_q  <= hsplit_d;
      ptr_q     <= ptr_d;
    end
  end

  assign HSPLITx       = hsplit_q;
  assign split_pending = pending_q;

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Directed and table-driven bench for ahb_split_ctrl with invariant checks under random traffic.
module tb_ahb_split_ctrl;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        res_busy;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] HSPLITx;
  logic        xfer_accept;
  logic [15:0] split_pending;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_split_ctrl #(
    .NUM_MASTERS (16),
    .MID_W       (4)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HSEL          (HSEL),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .HMASTER       (HMASTER),
    .HMASTLOCK     (HMASTLOCK),
    .res_busy      (res_busy),
    .HREADYOUT     (HREADYOUT),
    .HRESP         (HRESP),
    .HSPLITx       (HSPLITx),
    .xfer_accept   (xfer_accept),
    .split_pending (split_pending)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hready;
    logic [3:0]  hm;
    logic        lock;
    logic        busy;
    logic        rdy;
    logic [1:0]  resp;
    logic        acc;
    logic [15:0] split;
    logic [15:0] pend;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic set_in(input logic sel, input logic [1:0] tr, input logic rdy,
                        input logic [3:0] m, input logic lk, input logic bsy);
    HSEL      = sel;
    HTRANS    = tr;
    HREADY    = rdy;
    HMASTER   = m;
    HMASTLOCK = lk;
    res_busy  = bsy;
    #1;
  endtask

  task automatic idle_in(input logic bsy);
    set_in(1'b0, TransIdle, 1'b1, 4'd0, 1'b0, bsy);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  // Full split handshake from IDLE; returns with the FSM back in IDLE.
  task automatic do_split(input logic [3:0] m);
    set_in(1'b1, TransNonseq, 1'b1, m, 1'b0, 1'b1);
    next();
    idle_in(1'b1);
    next();
    next();
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [1:0] resp,
                         input logic acc, input logic [15:0] split, input logic [15:0] pend);
    chk({tag, ".rdy"}, 32'(HREADYOUT), 32'(rdy));
    chk({tag, ".resp"}, 32'(HRESP), 32'(resp));
    chk({tag, ".acc"}, 32'(xfer_accept), 32'(acc));
    chk({tag, ".hsplit"}, 32'(HSPLITx), 32'(split));
    chk({tag, ".pend"}, 32'(split_pending), 32'(pend));
  endtask

  logic        bsy_r;
  logic [15:0] prev_pend;

  initial begin
    //          sel   trans  rdy   hm     lk    bsy   | rdy  resp   acc   hsplit    pend
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b10, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b11, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b01, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b10, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b10, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b10, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 16'h0020});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0020});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0020});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0020});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0020, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b10, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b1, 2'b10, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b1, 2'b10, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0200});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0200, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000});

    // Reset state
    HRESET = 1'b1;
    idle_in(1'b0);
    next();
    next();
    chk_out("reset", 1'b1, RespOkay, 1'b0, 16'h0000, 16'h0000);
    HRESET = 1'b0;

    // Table: accept, zero-wait OKAY, split, release, ignored av in SPLIT2, idempotent split
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].hsel, vq[i].htrans, vq[i].hready, vq[i].hm, vq[i].lock, vq[i].busy);
      chk_out($sformatf("vec%0d", i), vq[i].rdy, vq[i].resp, vq[i].acc, vq[i].split,
              vq[i].pend);
      next();
    end

    // Release order: park the pointer at 8 by releasing master 7 first
    do_split(4'd7);
    idle_in(1'b0);
    chk("ptr8.pend", 32'(split_pending), 32'h0080);
    next();
    chk("ptr8.hsplit", 32'(HSPLITx), 32'h0080);
    chk("ptr8.pend_clr", 32'(split_pending), 32'h0000);
    do_split(4'd2);
    do_split(4'd7);
    do_split(4'd12);
    idle_in(1'b1);
    chk("rr.pend", 32'(split_pending), 32'h1084);
    chk("rr.busy_hsplit", 32'(HSPLITx), 32'h0000);
    idle_in(1'b0);
    next();
    chk("rr.hsplit0", 32'(HSPLITx), 32'h1000);
    chk("rr.pend0", 32'(split_pending), 32'h0084);
    next();
    chk("rr.hsplit1", 32'(HSPLITx), 32'h0004);
    chk("rr.pend1", 32'(split_pending), 32'h0080);
    next();
    chk("rr.hsplit2", 32'(HSPLITx), 32'h0080);
    chk("rr.pend2", 32'(split_pending), 32'h0000);
    next();
    chk("rr.hsplit3", 32'(HSPLITx), 32'h0000);

    // Locked hold: wait states, no split, accept when resource frees
    set_in(1'b1, TransNonseq, 1'b1, 4'd1, 1'b1, 1'b1);
    chk("lock.first_rdy", 32'(HREADYOUT), 32'd1);
    chk("lock.first_acc", 32'(xfer_accept), 32'd0);
    next();
    set_in(1'b0, TransIdle, 1'b0, 4'd1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("lock.wait%0d", k), 1'b0, RespOkay, 1'b0, 16'h0000, 16'h0000);
      next();
    end
    set_in(1'b0, TransIdle, 1'b0, 4'd1, 1'b1, 1'b0);
    chk("lock.rel_rdy", 32'(HREADYOUT), 32'd0);
    chk("lock.rel_acc", 32'(xfer_accept), 32'd1);
    next();
    idle_in(1'b0);
    chk_out("lock.done", 1'b1, RespOkay, 1'b0, 16'h0000, 16'h0000);

    // Reset in SPLIT1 with masters 1 and 2 pending
    do_split(4'd1);
    set_in(1'b1, TransNonseq, 1'b1, 4'd2, 1'b0, 1'b1);
    next();
    idle_in(1'b1);
    chk("rst.pre_rdy", 32'(HREADYOUT), 32'd0);
    chk("rst.pre_pend", 32'(split_pending), 32'h0006);
    HRESET = 1'b1;
    next();
    chk_out("rst.post", 1'b1, RespOkay, 1'b0, 16'h0000, 16'h0000);
    HRESET = 1'b0;
    next();
    chk("rst.idle_resp", 32'(HRESP), 32'(RespOkay));

    // Random traffic with invariant checks
    bsy_r     = 1'b0;
    prev_pend = split_pending;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) bsy_r = ~bsy_r;
      set_in(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(3) != 0),
             4'($urandom_range(15)), 1'($urandom_range(7) == 0), bsy_r);
      chk("rnd.onehot", 32'($countones(HSPLITx) <= 1), 32'd1);
      chk("rnd.subset", 32'(HSPLITx & ~prev_pend), 32'd0);
      chk("rnd.resp", 32'(HRESP == RespOkay || HRESP == RespSplit), 32'd1);
      prev_pend = split_pending;
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
